dsk_sector_server: RTL and testbench
====================================

// Module: dsk_sector_server
// PURPOSE
//  Serves u765 sector requests (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*) out of the SRAM image store
//  holding two DSK images, one per drive. Arbitrates the shared SRAM between drive 0 and drive 1
//  and sequences 512-byte sector transfers: SRAM->u765 buffer for reads, u765 buffer->SRAM for
//  writes. Sits between u765 and the SRAM, in place of the read-only image path.
// PARAMETERS
//  ADDR_W      19        SRAM byte-address width
//  DRV1_BASE   19'h40000 SRAM byte base of drive 1 image (drive 0 base is 0)
//  MAX_SECT    512       sectors per drive image; lba >= MAX_SECT is out of range
//  RD_LAT      1         SRAM read latency in clocks (addr -> sram_data_i valid), 1..3
// PORTS
//  clk_i         in   1       system clock
//  reset_i       in   1       synchronous, active-high reset
//  sd_lba        in   32      sector number requested by u765
//  sd_rd         in   2       per-drive read request, held until sd_ack seen
//  sd_wr         in   2       per-drive write request, held until sd_ack seen
//  wp_i          in   2       per-drive write protect
//  sd_ack        out  1       transfer in progress
//  sd_buff_addr  out  9       byte index within sector buffer
//  sd_buff_dout  out  8       read data to u765 buffer
//  sd_buff_din   in   8       write data from u765 buffer, valid 1 clk after sd_buff_addr
//  sd_buff_wr    out  1       strobe: write sd_buff_dout at sd_buff_addr
//  sram_addr_o   out  ADDR_W  SRAM byte address
//  sram_data_i   in   8       SRAM read data
//  sram_data_o   out  8       SRAM write data
//  sram_we_o     out  1       SRAM write strobe, one clk per byte
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, round-robin pointer = drive 1 (so drive 0 wins first tie).
//  Clock/reset: one clock domain, clk_i; reset_i synchronous active-high, dominates all; reset
//   mid-transfer aborts at once (sd_ack low next clk, no further sram_we_o or sd_buff_wr).
//  FSM: IDLE -> GRANT -> {RD_ADDR -> RD_WAIT -> RD_PUT | WR_ADDR -> WR_GET -> WR_PUT} -> DONE -> IDLE.
//  IDLE: req[d] = sd_rd[d]|sd_wr[d]. Both drives requesting: grant drive != last granted, then
//   pointer <= granted. Same drive rd and wr together: read served. Latch lba, drive, dir.
//  GRANT: sd_ack=1 (held through DONE); k=0. Range check: lba >= MAX_SECT -> oob flag.
//  Address: sram_addr_o = base(d) + {lba[8:0],k[8:0]}, truncated to ADDR_W (no carry past base).
//  Read byte k: RD_ADDR drives addr; RD_WAIT waits RD_LAT-1 clks; RD_PUT sd_buff_addr=k,
//   sd_buff_dout=sram_data_i (0x00 if oob), sd_buff_wr=1 exactly one clk. Cost RD_LAT+1 clks/byte.
//  Write byte k: WR_ADDR sd_buff_addr=k; WR_GET captures sd_buff_din; WR_PUT sram_data_o=byte,
//   sram_we_o=1 one clk unless oob or wp_i[d] (then discarded, sector still acked). 3 clks/byte.
//  k wraps: after k=511 -> DONE; DONE drops sd_ack; IDLE ignores requests 1 clk (u765 drops req).
//  sram_we_o never high in read path; sd_buff_wr never high in write path.
//  Requests arriving during a transfer wait; not lost while held high.
// TESTING
//  1 Drive0 read lba=1, SRAM[0x200..0x3FF]=i&FF -> 512 sd_buff_wr, addr 0..511, dout=addr&FF, then ack low.
//  2 Drive1 write lba=3, buffer=~addr -> SRAM[0x40600+k]=~k&FF, 512 sram_we_o pulses, drive0 area untouched.
//  3 sd_rd=2'b11 same clk -> drive0 served first, drive1 next; repeat tie -> order alternates.
//  4 Drive0 read lba=600 (>=512) -> 512 bytes of 0x00, sram_we_o never high; write lba=600 -> no SRAM write.
//  5 wp_i[0]=1, drive0 write lba=0 -> sd_ack cycle completes, SRAM[0..511] unchanged.
//  6 reset_i at byte 100 of read -> next clk sd_ack=0, sd_buff_wr=0; new read lba=0 then completes normally.
//  Sweep RD_LAT=1,2,3 on scenario 1: data correct, transfer = 512*(RD_LAT+1)+3 clks.

Source files
------------

// File: rtl/dsk_sector_server.sv
// Sector server between u765 and the two-drive DSK image SRAM.
// Arbitrates the drives and moves 512-byte sectors in either direction.
module dsk_sector_server #(
   parameter int                ADDR_W    = 19,
   parameter logic [ADDR_W-1:0] DRV1_BASE = ADDR_W'(19'h40000),
   parameter int                MAX_SECT  = 512,
   parameter int                RD_LAT    = 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [31:0]       sd_lba,
   input  logic [1:0]        sd_rd,
   input  logic [1:0]        sd_wr,
   input  logic [1:0]        wp_i,
   output logic              sd_ack,
   output logic [8:0]        sd_buff_addr,
   output logic [7:0]        sd_buff_dout,
   input  logic [7:0]        sd_buff_din,
   output logic              sd_buff_wr,
   output logic [ADDR_W-1:0] sram_addr_o,
   input  logic [7:0]        sram_data_i,
   output logic [7:0]        sram_data_o,
   output logic              sram_we_o
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_GRANT,
      S_RD_ADDR,
      S_RD_WAIT,
      S_RD_PUT,
      S_WR_ADDR,
      S_WR_GET,
      S_WR_PUT,
      S_DONE
   } state_t;

   localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);
   localparam logic [8:0] K_LAST    = 9'd511;

   state_t      state;
   logic        rr_q;
   logic        drv_q;
   logic        wr_q;
   logic        oob_q;
   logic        hold_q;
   logic [31:0] lba_q;
   logic [8:0]  k_q;
   logic [1:0]  wait_q;

   logic [1:0]  req;
   logic        gnt;
   logic        gnt_wr;

   function automatic logic [ADDR_W-1:0] sect_addr(
      input logic       d,
      input logic [8:0] l,
      input logic [8:0] k
   );
      logic [ADDR_W-1:0] base;
      base = d ? DRV1_BASE : '0;
      return base + ADDR_W'({l, k});
   endfunction

   // On a tie the drive not granted last time wins; read beats write.
   always_comb begin
      req = sd_rd | sd_wr;
      if (req[0] && req[1]) begin
         gnt = ~rr_q;
      end else begin
         gnt = req[1];
      end
      gnt_wr = ~sd_rd[gnt];
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state        <= S_IDLE;
         rr_q         <= 1'b1;
         drv_q        <= 1'b0;
         wr_q         <= 1'b0;
         oob_q        <= 1'b0;
         hold_q       <= 1'b0;
         lba_q        <= '0;
         k_q          <= '0;
         wait_q       <= '0;
         sd_ack       <= 1'b0;
         sd_buff_addr <= '0;
         sd_buff_dout <= '0;
         sd_buff_wr   <= 1'b0;
         sram_addr_o  <= '0;
         sram_data_o  <= '0;
         sram_we_o    <= 1'b0;
      end else begin
         sd_buff_wr <= 1'b0;
         sram_we_o  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (hold_q) begin
                  hold_q <= 1'b0;
               end else if (|req) begin
                  if (req[0] && req[1]) begin
                     rr_q <= gnt;
                  end
                  drv_q  <= gnt;
                  wr_q   <= gnt_wr;
                  lba_q  <= sd_lba;
                  sd_ack <= 1'b1;
                  state  <= S_GRANT;
               end
            end
            S_GRANT: begin
               oob_q  <= (lba_q >= 32'(MAX_SECT));
               k_q    <= '0;
               wait_q <= '0;
               if (wr_q) begin
                  sd_buff_addr <= '0;
                  state        <= S_WR_ADDR;
               end else begin
                  sram_addr_o <= sect_addr(drv_q, lba_q[8:0], 9'd0);
                  state       <= S_RD_ADDR;
               end
            end
            S_RD_ADDR: begin
               wait_q <= 2'd1;
               if (RD_LAT > 1) begin
                  state <= S_RD_WAIT;
               end else begin
                  state <= S_RD_PUT;
               end
            end
            S_RD_WAIT: begin
               if (wait_q >= WAIT_LAST) begin
                  state <= S_RD_PUT;
               end else begin
                  wait_q <= wait_q + 2'd1;
               end
            end
            S_RD_PUT: begin
               sd_buff_addr <= k_q;
               sd_buff_dout <= oob_q ? 8'h00 : sram_data_i;
               sd_buff_wr   <= 1'b1;
               if (k_q == K_LAST) begin
                  state <= S_DONE;
               end else begin
                  k_q         <= k_q + 9'd1;
                  sram_addr_o <= sect_addr(drv_q, lba_q[8:0], k_q + 9'd1);
                  state       <= S_RD_ADDR;
               end
            end
            S_WR_ADDR: begin
               state <= S_WR_GET;
            end
            // Buffer data lags its address by one clock.
            S_WR_GET: begin
               sram_data_o <= sd_buff_din;
               sram_addr_o <= sect_addr(drv_q, lba_q[8:0], k_q);
               sram_we_o   <= ~(oob_q | wp_i[drv_q]);
               state       <= S_WR_PUT;
            end
            S_WR_PUT: begin
               if (k_q == K_LAST) begin
                  state <= S_DONE;
               end else begin
                  k_q          <= k_q + 9'd1;
                  sd_buff_addr <= k_q + 9'd1;
                  state        <= S_WR_ADDR;
               end
            end
            S_DONE: begin
               sd_ack <= 1'b0;
               hold_q <= 1'b1;
               state  <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dsk_sector_server.sv
// Directed bench for dsk_sector_server with byte-level scoreboards.
// Extra instances cover read latencies 2 and 3.
module tb_dsk_sector_server;

   typedef struct packed {
      logic [8:0] a;
      logic [7:0] d;
   } bexp_t;

   typedef struct packed {
      logic [18:0] a;
      logic [7:0]  d;
   } sexp_t;

   logic        clk = 1'b0;
   logic        reset_i;
   logic [31:0] sd_lba;
   logic [1:0]  sd_rd;
   logic [1:0]  sd_wr;
   logic [1:0]  wp_i;
   logic        sd_ack;
   logic [8:0]  sd_buff_addr;
   logic [7:0]  sd_buff_dout;
   logic [7:0]  sd_buff_din;
   logic        sd_buff_wr;
   logic [18:0] sram_addr_o;
   logic [7:0]  sram_data_i;
   logic [7:0]  sram_data_o;
   logic        sram_we_o;

   logic [1:0]  swp_rd [2:3];
   logic        swp_ack[2:3];
   logic [8:0]  swp_ba [2:3];
   logic [7:0]  swp_bd [2:3];
   logic        swp_bw [2:3];
   logic [18:0] swp_sa [2:3];
   logic [7:0]  swp_si [2:3];
   logic [7:0]  swp_so [2:3];
   logic        swp_we [2:3];

   logic [7:0]  mem [0:(1<<19)-1];
   bit          wrt [0:(1<<19)-1];
   logic [7:0]  wbuf[0:511];
   logic [7:0]  refw[int];

   bexp_t exp_b[$];
   sexp_t exp_s[$];
   int    checks = 0;
   int    errors = 0;
   int    bwr_cnt = 0;
   int    swe_cnt = 0;
   int    lane_n  [2:3];
   int    lane_ack[2:3];

   always #5 clk = ~clk;

   dsk_sector_server #(
      .ADDR_W(19), .DRV1_BASE(19'h40000), .MAX_SECT(512), .RD_LAT(1)
   ) u_dut (
      .clk_i(clk), .reset_i(reset_i), .sd_lba(sd_lba),
      .sd_rd(sd_rd), .sd_wr(sd_wr), .wp_i(wp_i), .sd_ack(sd_ack),
      .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
      .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr),
      .sram_addr_o(sram_addr_o), .sram_data_i(sram_data_i),
      .sram_data_o(sram_data_o), .sram_we_o(sram_we_o)
   );

   function automatic logic [7:0] img(input int a);
      return (a < 'h40000) ? a[7:0] : (a[7:0] ^ 8'hA5);
   endfunction

   always @(posedge clk) begin
      if (sram_we_o) begin
         mem[sram_addr_o] <= sram_data_o;
         wrt[sram_addr_o] <= 1'b1;
      end
      sram_data_i <= wrt[sram_addr_o] ? mem[sram_addr_o] : img(int'(sram_addr_o));
   end

   always @(posedge clk) sd_buff_din <= wbuf[sd_buff_addr];

   for (genvar g = 2; g <= 3; g++) begin : g_lat
      logic [7:0] pipe [0:g-1];
      always @(posedge clk) begin
         pipe[0] <= swp_sa[g][7:0];
         for (int j = 1; j < g; j++) pipe[j] <= pipe[j-1];
      end
      assign swp_si[g] = pipe[g-1];
      dsk_sector_server #(
         .ADDR_W(19), .DRV1_BASE(19'h40000), .MAX_SECT(512), .RD_LAT(g)
      ) u_lat (
         .clk_i(clk), .reset_i(reset_i), .sd_lba(32'd1),
         .sd_rd(swp_rd[g]), .sd_wr(2'b00), .wp_i(2'b00), .sd_ack(swp_ack[g]),
         .sd_buff_addr(swp_ba[g]), .sd_buff_dout(swp_bd[g]),
         .sd_buff_din(8'h00), .sd_buff_wr(swp_bw[g]),
         .sram_addr_o(swp_sa[g]), .sram_data_i(swp_si[g]),
         .sram_data_o(swp_so[g]), .sram_we_o(swp_we[g])
      );
   end

   function automatic int addr_of(input int d, input int lba, input int k);
      return ((d != 0 ? 'h40000 : 0) + (lba % 512) * 512 + k) % 'h80000;
   endfunction

   function automatic logic [7:0] ref_rd(input int a);
      return refw.exists(a) ? refw[a] : img(a);
   endfunction

   function automatic logic [7:0] sram_rd(input int a);
      return wrt[a] ? mem[a] : img(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_rd(input int d, input int lba);
      bexp_t e;
      for (int k = 0; k < 512; k++) begin
         e.a = 9'(k);
         e.d = (lba >= 512) ? 8'h00 : ref_rd(addr_of(d, lba, k));
         exp_b.push_back(e);
      end
   endtask

   task automatic push_wr(input int d, input int lba, input bit wp);
      sexp_t s;
      int    a;
      if (lba < 512 && !wp) begin
         for (int k = 0; k < 512; k++) begin
            a = addr_of(d, lba, k);
            s.a = 19'(a);
            s.d = wbuf[k];
            exp_s.push_back(s);
            refw[a] = wbuf[k];
         end
      end
   endtask

   task automatic mon();
      bexp_t e;
      sexp_t s;
      if (sd_buff_wr) begin
         bwr_cnt++;
         chk("sd_buff_wr expected", 32'(exp_b.size() != 0), 1);
         if (exp_b.size() != 0) begin
            e = exp_b.pop_front();
            chk("buff addr", sd_buff_addr, e.a);
            chk("buff data", sd_buff_dout, e.d);
         end
      end
      if (sram_we_o) begin
         swe_cnt++;
         chk("sram_we expected", 32'(exp_s.size() != 0), 1);
         if (exp_s.size() != 0) begin
            s = exp_s.pop_front();
            chk("sram addr", sram_addr_o, s.a);
            chk("sram data", sram_data_o, s.d);
         end
      end
      for (int g = 2; g <= 3; g++) begin
         if (swp_ack[g]) begin
            lane_ack[g]++;
            swp_rd[g] = 2'b00;
         end
         if (swp_bw[g]) begin
            chk("lat buff addr", swp_ba[g], lane_n[g]);
            chk("lat buff data", swp_bd[g], 32'(lane_n[g] & 255));
            lane_n[g]++;
         end
         chk("lat no sram_we", swp_we[g], 0);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      mon();
   endtask

   task automatic serve(input int d, input string tag, output int ackc);
      int n;
      n = 0;
      while (sd_ack !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk({tag, " ack rise"}, sd_ack, 1);
      sd_rd[d] = 1'b0;
      sd_wr[d] = 1'b0;
      ackc = 0;
      while (sd_ack === 1'b1 && ackc < 3000) begin
         ackc++;
         tick();
      end
      chk({tag, " ack fall"}, sd_ack, 0);
   endtask

   task automatic region(input string tag, input int lo, input int hi);
      int bad;
      bad = 0;
      for (int a = lo; a <= hi; a++) if (sram_rd(a) !== ref_rd(a)) bad++;
      chk(tag, bad, 0);
   endtask

   initial begin
      int ackc, base, n, we0;
      reset_i = 1'b1;
      sd_lba  = '0;
      sd_rd   = '0;
      sd_wr   = '0;
      wp_i    = '0;
      swp_rd[2] = '0;
      swp_rd[3] = '0;
      lane_n[2] = 0;
      lane_n[3] = 0;
      lane_ack[2] = 0;
      lane_ack[3] = 0;
      for (int k = 0; k < 512; k++) wbuf[k] = 8'(k * 7 + 3);
      repeat (3) tick();
      chk("rst sd_ack", sd_ack, 0);
      chk("rst sd_buff_wr", sd_buff_wr, 0);
      chk("rst sd_buff_addr", sd_buff_addr, 0);
      chk("rst sd_buff_dout", sd_buff_dout, 0);
      chk("rst sram_addr_o", sram_addr_o, 0);
      chk("rst sram_data_o", sram_data_o, 0);
      chk("rst sram_we_o", sram_we_o, 0);
      reset_i = 1'b0;
      tick();

      // drive 0, lba 1, latency 1
      push_rd(0, 1);
      sd_lba = 32'd1;
      sd_rd  = 2'b01;
      base   = bwr_cnt;
      serve(0, "s1", ackc);
      chk("s1 xfer clks", ackc + 1, 512 * 2 + 3);
      chk("s1 bytes", bwr_cnt - base, 512);
      chk("s1 queue", exp_b.size(), 0);

      swp_rd[2] = 2'b01;
      swp_rd[3] = 2'b01;
      n = 0;
      while ((lane_n[2] < 512 || lane_n[3] < 512 || swp_ack[2] || swp_ack[3]) && n < 5000) begin
         tick();
         n++;
      end
      for (int g = 2; g <= 3; g++) begin
         chk("lat bytes", lane_n[g], 512);
         chk("lat xfer clks", lane_ack[g] + 1, 512 * (g + 1) + 3);
      end

      for (int k = 0; k < 512; k++) wbuf[k] = ~8'(k);
      push_wr(1, 3, 1'b0);
      sd_lba = 32'd3;
      sd_wr  = 2'b10;
      we0    = swe_cnt;
      base   = bwr_cnt;
      serve(1, "s2", ackc);
      chk("s2 we pulses", swe_cnt - we0, 512);
      chk("s2 no buff_wr", bwr_cnt - base, 0);
      chk("s2 queue", exp_s.size(), 0);
      n = 0;
      for (int k = 0; k < 512; k++) if (sram_rd('h40600 + k) !== ~8'(k)) n++;
      chk("s2 drive1 sector", n, 0);
      region("s2 drive0 untouched", 0, 'h3FFFF);

      push_rd(0, 2);
      push_rd(1, 2);
      sd_lba = 32'd2;
      sd_rd  = 2'b11;
      serve(0, "s3a d0", ackc);
      serve(1, "s3a d1", ackc);
      chk("s3a queue", exp_b.size(), 0);
      push_rd(1, 2);
      push_rd(0, 2);
      sd_rd = 2'b11;
      serve(1, "s3b d1", ackc);
      serve(0, "s3b d0", ackc);
      chk("s3b queue", exp_b.size(), 0);

      push_rd(0, 600);
      sd_lba = 32'd600;
      sd_rd  = 2'b01;
      we0    = swe_cnt;
      serve(0, "s4 rd", ackc);
      chk("s4 rd no we", swe_cnt - we0, 0);
      chk("s4 rd queue", exp_b.size(), 0);
      for (int k = 0; k < 512; k++) wbuf[k] = 8'($urandom_range(0, 255));
      push_wr(0, 600, 1'b0);
      sd_wr = 2'b01;
      serve(0, "s4 wr", ackc);
      chk("s4 wr no we", swe_cnt - we0, 0);

      wp_i = 2'b01;
      push_wr(0, 0, 1'b1);
      sd_lba = 32'd0;
      sd_wr  = 2'b01;
      serve(0, "s5", ackc);
      chk("s5 no we", swe_cnt - we0, 0);
      region("s5 sector0 kept", 0, 511);
      wp_i = 2'b00;

      push_rd(0, 5);
      sd_lba = 32'd5;
      sd_rd  = 2'b01;
      base   = bwr_cnt;
      n = 0;
      while (sd_ack !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      sd_rd = 2'b00;
      n = 0;
      while (bwr_cnt - base < 100 && n < 2000) begin
         tick();
         n++;
      end
      chk("s6 reached byte 100", bwr_cnt - base, 100);
      reset_i = 1'b1;
      tick();
      chk("s6 abort ack", sd_ack, 0);
      chk("s6 abort buff_wr", sd_buff_wr, 0);
      reset_i = 1'b0;
      exp_b.delete();
      tick();
      chk("s6 quiet", bwr_cnt - base, 100);
      push_rd(0, 0);
      sd_lba = 32'd0;
      sd_rd  = 2'b01;
      serve(0, "s6 rd", ackc);
      chk("s6 rd bytes", bwr_cnt - base, 612);
      chk("s6 queue", exp_b.size(), 0);
      chk("final sram queue", exp_s.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
